// File: rtl/tick_rate_controller.sv
// tick_rate_controller: run-time programmable clock-enable generator.
// One divide counter produces a one-cycle tick strobe every div_q cycles and a
// phase output that toggles on each tick. New divide values arrive over a
// valid/ready port and are only applied on a tick boundary (or when stopping),
// so a running period is never cut short.
//
// Handshake: a transfer happens on a rising clk_i edge where cfg_valid_i and
// cfg_ready_o are both 1. cfg_ready_o depends only on state (never on
// cfg_valid_i); it is 0 while a change is already pending, and the offerer may
// keep cfg_valid_i high until it sees ready. A zero divide value still
// completes the transfer but is discarded and flagged on cfg_err_o.
module tick_rate_controller #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             tick_o,
  output logic             phase_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             err_q, err_d;

  logic             accept;
  logic             accept_ok;
  logic             boundary;

  assign cfg_ready_o = (state_q != ST_PEND);
  assign busy_o      = (state_q == ST_PEND);
  assign tick_o      = tick_q;
  assign phase_o     = phase_q;
  assign cfg_err_o   = err_q;
  assign dbg_state_o = state_q;

  assign accept    = cfg_valid_i & cfg_ready_o;
  assign accept_ok = accept & (cfg_div_i != '0);
  // div_q is never 0, so div_q-1 cannot wrap and cnt_q stays below div_q.
  assign boundary  = (cnt_q == (div_q - ONE));

  // Next-state, counter and strobe computation for the divide sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    err_d   = accept & (cfg_div_i == '0);

    unique case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (accept_ok) div_d = cfg_div_i;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_i) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (accept_ok) div_d = cfg_div_i;
        end else if (boundary) begin
          // Tick with the old period; a value offered on this very edge
          // applies straight away without visiting PEND.
          cnt_d   = '0;
          tick_d  = 1'b1;
          phase_d = ~phase_q;
          if (accept_ok) div_d = cfg_div_i;
        end else begin
          cnt_d = cnt_q + ONE;
          if (accept_ok) begin
            pend_d  = cfg_div_i;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!en_i) begin
          cnt_d   = '0;
          div_d   = pend_q;
          state_d = ST_STOP;
        end else if (boundary) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          phase_d = ~phase_q;
          div_d   = pend_q;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STOP;
      end
    endcase
  end

  // State and registered outputs; reset restores the power-up divide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_STOP;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      pend_q  <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

endmodule
